// File: rtl/usb_rx_core.sv
// rtl/usb_rx_core.sv - USB full-speed receive path: line sampling, NRZI decode, unstuffing, packet decode
module usb_rx_core #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       dplus_in,
    input  logic       dminus_in,
    output logic [2:0] rx_packet,
    output logic       rx_transfer_active,
    output logic       rx_error,
    output logic       rx_data_ready,
    output logic       store_rx_packet_data,
    output logic [7:0] rx_packet_data
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(MAX_PAYLOAD + 3);
    localparam logic [1:0] LINE_J = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_TOKEN, S_HAND, S_DATA, S_EOP, S_ERR} state_t;

    state_t          state;
    logic            dp_s1, dp_s2, dm_s1, dm_s2, dp_prev;
    logic [CW-1:0]   cnt;
    logic [1:0]      prev_line;
    logic [2:0]      ones;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic [BW-1:0]   byte_cnt;
    logic [7:0]      hold0, hold1;
    logic [1:0]      se0_cnt;
    logic [2:0]      j_cnt;
    logic            pkt_data;

    logic [1:0] line;
    logic       edge_seen, sample, is_j, is_k, is_se0, nrzi_bit, stuff_drop, byte_done, err_now;
    logic [7:0] new_byte;
    logic [2:0] pid_cls;

    function automatic logic [2:0] pid_class(input logic [7:0] p);
        case (p)
            8'hE1:        pid_class = 3'd1;
            8'h69:        pid_class = 3'd2;
            8'hC3, 8'h4B: pid_class = 3'd3;
            8'hD2:        pid_class = 3'd4;
            8'h5A:        pid_class = 3'd5;
            8'h1E:        pid_class = 3'd6;
            default:      pid_class = 3'd0;
        endcase
    endfunction

    assign line       = {dp_s2, dm_s2};
    assign edge_seen  = dp_s2 != dp_prev;
    assign sample     = !edge_seen && (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign is_j       = line == LINE_J;
    assign is_k       = line == 2'b01;
    assign is_se0     = line == 2'b00;
    assign nrzi_bit   = line == prev_line;
    assign stuff_drop = ones == 3'd6;
    assign new_byte   = {nrzi_bit, shreg[7:1]};
    assign byte_done  = !stuff_drop && (bitcnt == 3'd7);
    assign pid_cls    = pid_class(new_byte);

    always_comb begin
        err_now = 1'b0;
        if (sample) begin
            case (state)
                S_SYNC, S_PID, S_TOKEN, S_HAND, S_DATA: begin
                    if (is_se0)
                        err_now = (bitcnt != 3'd0) ||
                                  !((state == S_TOKEN && byte_cnt == BW'(2)) || state == S_HAND ||
                                    (state == S_DATA && byte_cnt >= BW'(2)));
                    else if (!is_j && !is_k)
                        err_now = 1'b1;
                    else if (state == S_HAND)
                        err_now = 1'b1;
                    else if (stuff_drop)
                        err_now = nrzi_bit;
                    else if (byte_done) begin
                        case (state)
                            S_SYNC:  err_now = new_byte != 8'h80;
                            S_PID:   err_now = pid_cls == 3'd0;
                            S_TOKEN: err_now = byte_cnt == BW'(2);
                            default: err_now = byte_cnt == BW'(MAX_PAYLOAD + 2);
                        endcase
                    end
                end
                S_EOP: begin
                    if (is_se0)    err_now = se0_cnt == 2'd2;
                    else if (is_j) err_now = se0_cnt != 2'd2;
                    else           err_now = 1'b1;
                end
                default: err_now = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state                <= S_IDLE;
            dp_s1                <= 1'b1;
            dp_s2                <= 1'b1;
            dm_s1                <= 1'b0;
            dm_s2                <= 1'b0;
            dp_prev              <= 1'b1;
            cnt                  <= '0;
            prev_line            <= LINE_J;
            ones                 <= '0;
            bitcnt               <= '0;
            shreg                <= '0;
            byte_cnt             <= '0;
            hold0                <= '0;
            hold1                <= '0;
            se0_cnt              <= '0;
            j_cnt                <= '0;
            pkt_data             <= 1'b0;
            rx_packet            <= '0;
            rx_transfer_active   <= 1'b0;
            rx_error             <= 1'b0;
            rx_data_ready        <= 1'b0;
            store_rx_packet_data <= 1'b0;
            rx_packet_data       <= '0;
        end else begin
            dp_s1   <= dplus_in;
            dp_s2   <= dp_s1;
            dm_s1   <= dminus_in;
            dm_s2   <= dm_s1;
            dp_prev <= dp_s2;
            // Every D+ edge re-centres the sampling point on the new bit
            if (edge_seen)
                cnt <= '0;
            else
                cnt <= (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + CW'(1);

            store_rx_packet_data <= 1'b0;
            rx_data_ready        <= 1'b0;

            if (sample) begin
                prev_line <= line;
                if (err_now) begin
                    state    <= S_ERR;
                    rx_error <= 1'b1;
                    se0_cnt  <= {1'b0, is_se0};
                    j_cnt    <= {2'b0, is_j};
                end else begin
                    case (state)
                        S_IDLE: if (is_k && prev_line == LINE_J) begin
                            state              <= S_SYNC;
                            rx_packet          <= '0;
                            rx_error           <= 1'b0;
                            rx_transfer_active <= 1'b1;
                            shreg              <= new_byte;
                            bitcnt             <= 3'd1;
                            ones               <= '0;
                            byte_cnt           <= '0;
                        end
                        S_SYNC, S_PID, S_TOKEN, S_HAND, S_DATA: begin
                            if (is_se0) begin
                                state    <= S_EOP;
                                se0_cnt  <= 2'd1;
                                pkt_data <= state == S_DATA;
                            end else if (stuff_drop) begin
                                ones <= '0;
                            end else begin
                                ones   <= nrzi_bit ? ones + 3'd1 : 3'd0;
                                shreg  <= new_byte;
                                bitcnt <= bitcnt + 3'd1;
                                if (byte_done) begin
                                    case (state)
                                        S_SYNC: state <= S_PID;
                                        S_PID: begin
                                            rx_packet <= pid_cls;
                                            byte_cnt  <= '0;
                                            if (pid_cls == 3'd3)
                                                state <= S_DATA;
                                            else if (pid_cls == 3'd1 || pid_cls == 3'd2)
                                                state <= S_TOKEN;
                                            else
                                                state <= S_HAND;
                                        end
                                        S_TOKEN: byte_cnt <= byte_cnt + BW'(1);
                                        default: begin
                                            // Two-byte delay line keeps the trailing CRC16 out of the buffer
                                            byte_cnt <= byte_cnt + BW'(1);
                                            hold0    <= new_byte;
                                            hold1    <= hold0;
                                            if (byte_cnt >= BW'(2)) begin
                                                store_rx_packet_data <= 1'b1;
                                                rx_packet_data       <= hold1;
                                            end
                                        end
                                    endcase
                                end
                            end
                        end
                        S_EOP: begin
                            if (is_se0) begin
                                se0_cnt <= 2'd2;
                            end else begin
                                state              <= S_IDLE;
                                rx_transfer_active <= 1'b0;
                                rx_data_ready      <= pkt_data;
                            end
                        end
                        S_ERR: begin
                            if (is_j) begin
                                se0_cnt <= '0;
                                j_cnt   <= j_cnt + 3'd1;
                                if (se0_cnt == 2'd2 || j_cnt == 3'd7) begin
                                    state              <= S_IDLE;
                                    rx_transfer_active <= 1'b0;
                                end
                            end else if (is_se0) begin
                                j_cnt   <= '0;
                                se0_cnt <= (se0_cnt == 2'd2) ? 2'd2 : se0_cnt + 2'd1;
                            end else begin
                                j_cnt   <= '0;
                                se0_cnt <= '0;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_core.sv
// tb/tb_usb_rx_core.sv - scoreboard bench for usb_rx_core driving NRZI/bit-stuffed line traffic
module tb_usb_rx_core;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       dplus = 1'b1;
    logic       dminus = 1'b0;
    logic [2:0] rx_packet;
    logic       rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data;
    logic [7:0] rx_packet_data;

    usb_rx_core #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
        .clk(clk), .n_rst(n_rst), .dplus_in(dplus), .dminus_in(dminus),
        .rx_packet(rx_packet), .rx_transfer_active(rx_transfer_active), .rx_error(rx_error),
        .rx_data_ready(rx_data_ready), .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data(rx_packet_data)
    );

    always #5 clk = ~clk;

    logic [7:0] obs_mem [0:255];
    int obs_wr = 0;
    int rdy_cnt = 0;

    always @(negedge clk) begin
        if (store_rx_packet_data) begin
            obs_mem[obs_wr[7:0]] = rx_packet_data;
            obs_wr = obs_wr + 1;
        end
        if (rx_data_ready) rdy_cnt = rdy_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    int obs_rd = 0;
    logic line_j = 1'b1;
    int ones_tx = 0;

    task automatic drive(input logic dp, input logic dm);
        dplus = dp;
        dminus = dm;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic tx_bit(input logic b);
        if (!b) line_j = !line_j;
        drive(line_j, !line_j);
    endtask

    task automatic send_bit(input logic b);
        tx_bit(b);
        if (b) begin
            ones_tx++;
            if (ones_tx == 6) begin
                tx_bit(1'b0);
                ones_tx = 0;
            end
        end else begin
            ones_tx = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_start(input logic [7:0] pid);
        ones_tx = 0;
        send_byte(8'h80);
        send_byte(pid);
    endtask

    task automatic send_eop();
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        line_j = 1'b1;
    endtask

    task automatic send_idle(input int n);
        line_j = 1'b1;
        repeat (n) drive(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({rx_packet, rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data, rx_packet_data} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_in: outputs %0h want 0", {rx_packet, rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data, rx_packet_data});
        end
        n_rst = 1'b1;
        send_idle(4);
        #1;
        n_cmp++;
        if ({rx_packet, rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_idle: outputs %0h want 0", {rx_packet, rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data});
        end
    endtask

    task automatic test_out_token();
        int base_wr;
        base_wr = obs_wr;
        send_idle(2);
        send_start(8'hE1);
        #1;
        n_cmp++;
        if (rx_transfer_active !== 1'b1) begin n_bad++; $display("FAIL out_active_mid: got %0b want 1", rx_transfer_active); end
        send_byte(8'h05);
        send_byte(8'h08);
        #1;
        n_cmp++;
        if (rx_transfer_active !== 1'b1) begin n_bad++; $display("FAIL out_active_pre_eop: got %0b want 1", rx_transfer_active); end
        send_eop();
        #1;
        n_cmp++;
        if (rx_packet !== 3'd1) begin n_bad++; $display("FAIL out_packet: got %0d want 1", rx_packet); end
        n_cmp++;
        if (rx_transfer_active !== 1'b0 || rx_error !== 1'b0) begin
            n_bad++; $display("FAIL out_flags: active %0b error %0b want 0 0", rx_transfer_active, rx_error);
        end
        n_cmp++;
        if (obs_wr != base_wr) begin n_bad++; $display("FAIL out_strobes: got %0d want 0", obs_wr - base_wr); end
        obs_rd = obs_wr;
    endtask

    task automatic test_data0();
        logic [7:0] pay [5];
        logic [7:0] e;
        int rdy0;
        pay = '{8'hA5, 8'hFF, 8'h00, 8'h12, 8'h34};
        rdy0 = rdy_cnt;
        send_idle(3);
        send_start(8'hC3);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) exp_q.push_back(pay[i]);
            send_byte(pay[i]);
        end
        send_eop();
        send_idle(1);
        #1;
        n_cmp++;
        if (obs_wr - obs_rd != 3) begin n_bad++; $display("FAIL data0_count: got %0d want 3", obs_wr - obs_rd); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                n_cmp++;
                if (obs_mem[obs_rd[7:0]] !== e) begin n_bad++; $display("FAIL data0_byte: got %0h want %0h", obs_mem[obs_rd[7:0]], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_wr;
        n_cmp++;
        if (rdy_cnt - rdy0 != 1) begin n_bad++; $display("FAIL data0_ready: got %0d want 1", rdy_cnt - rdy0); end
        n_cmp++;
        if (rx_packet !== 3'd3 || rx_error !== 1'b0) begin
            n_bad++; $display("FAIL data0_status: packet %0d error %0b want 3 0", rx_packet, rx_error);
        end
    endtask

    task automatic test_bad_pid();
        send_idle(3);
        send_start(8'h2E);
        send_eop();
        send_idle(1);
        #1;
        n_cmp++;
        if (rx_error !== 1'b1 || rx_packet !== 3'd0) begin
            n_bad++; $display("FAIL badpid_status: error %0b packet %0d want 1 0", rx_error, rx_packet);
        end
        n_cmp++;
        if (obs_wr != obs_rd) begin n_bad++; $display("FAIL badpid_strobes: got %0d want 0", obs_wr - obs_rd); end
        send_idle(2);
        send_start(8'h5A);
        send_eop();
        send_idle(1);
        #1;
        n_cmp++;
        if (rx_packet !== 3'd5 || rx_error !== 1'b0) begin
            n_bad++; $display("FAIL nak_status: packet %0d error %0b want 5 0", rx_packet, rx_error);
        end
        obs_rd = obs_wr;
    endtask

    task automatic test_stuff_error();
        logic [7:0] e;
        int rdy0;
        rdy0 = rdy_cnt;
        send_idle(3);
        send_start(8'h4B);
        exp_q.push_back(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        for (int i = 0; i < 6; i++) tx_bit(1'b1);
        #1;
        n_cmp++;
        if (rx_error !== 1'b0) begin n_bad++; $display("FAIL stuff_six_ones: error %0b want 0", rx_error); end
        tx_bit(1'b1);
        #1;
        n_cmp++;
        if (rx_error !== 1'b1) begin n_bad++; $display("FAIL stuff_seventh_one: error %0b want 1", rx_error); end
        send_eop();
        send_idle(1);
        #1;
        n_cmp++;
        if (obs_wr - obs_rd != 1) begin n_bad++; $display("FAIL stuff_count: got %0d want 1", obs_wr - obs_rd); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                n_cmp++;
                if (obs_mem[obs_rd[7:0]] !== e) begin n_bad++; $display("FAIL stuff_byte: got %0h want %0h", obs_mem[obs_rd[7:0]], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_wr;
        n_cmp++;
        if (rdy_cnt != rdy0 || rx_error !== 1'b1) begin
            n_bad++; $display("FAIL stuff_ready: ready pulses %0d error %0b want 0 1", rdy_cnt - rdy0, rx_error);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [7:0] e;
        int rdy0;
        rdy0 = rdy_cnt;
        send_idle(3);
        send_start(8'hC3);
        for (int i = 0; i < 67; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 64) exp_q.push_back(b);
            send_byte(b);
            if (i == 65) begin
                #1;
                n_cmp++;
                if (rx_error !== 1'b0) begin n_bad++; $display("FAIL ovf_66_bytes: error %0b want 0", rx_error); end
            end
        end
        #1;
        n_cmp++;
        if (rx_error !== 1'b1) begin n_bad++; $display("FAIL ovf_67_bytes: error %0b want 1", rx_error); end
        send_eop();
        send_idle(1);
        #1;
        n_cmp++;
        if (obs_wr - obs_rd != 64) begin n_bad++; $display("FAIL ovf_count: got %0d want 64", obs_wr - obs_rd); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                n_cmp++;
                if (obs_mem[obs_rd[7:0]] !== e) begin n_bad++; $display("FAIL ovf_byte: got %0h want %0h", obs_mem[obs_rd[7:0]], e); end
                obs_rd++;
            end
        end
        obs_rd = obs_wr;
        n_cmp++;
        if (rdy_cnt != rdy0) begin n_bad++; $display("FAIL ovf_ready: got %0d want 0", rdy_cnt - rdy0); end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] e;
        send_idle(3);
        send_start(8'hC3);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        send_byte(8'h81);
        send_byte(8'h7E);
        #1;
        n_cmp++;
        if (obs_wr - obs_rd != 1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", obs_wr - obs_rd); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_wr) begin
                n_cmp++;
                if (obs_mem[obs_rd[7:0]] !== e) begin n_bad++; $display("FAIL rstmid_byte: got %0h want %0h", obs_mem[obs_rd[7:0]], e); end
                obs_rd++;
            end
        end
        n_rst = 1'b0;
        line_j = 1'b1;
        dplus = 1'b1;
        dminus = 1'b0;
        #1;
        n_cmp++;
        if ({rx_packet, rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data, rx_packet_data} !== 15'd0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %0h want 0", {rx_packet, rx_transfer_active, rx_error, rx_data_ready, store_rx_packet_data, rx_packet_data});
        end
        repeat (4) @(posedge clk);
        n_rst = 1'b1;
        send_idle(3);
        send_start(8'hD2);
        send_eop();
        send_idle(1);
        #1;
        n_cmp++;
        if (rx_packet !== 3'd4 || rx_error !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_ack: packet %0d error %0b want 4 0", rx_packet, rx_error);
        end
        n_cmp++;
        if (obs_wr != obs_rd) begin n_bad++; $display("FAIL rstmid_strobes: got %0d want 0", obs_wr - obs_rd); end
        obs_rd = obs_wr;
    endtask

    initial begin
        test_reset();
        test_out_token();
        test_data0();
        test_bad_pid();
        test_stuff_error();
        test_overflow();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
